// File: rtl/incr_pack.sv
// incr_pack: packs 4-bit incrementer results, LSB nibble first, into NIBBLES*4-bit words.
// Latency: a word completed by a nibble in cycle t is valid in cycle t+1; a flush emits one cycle after it is pending.
// Backpressure: a single output holding register; nib_ready_o drops when a completing nibble or a pending flush would need the busy output.
// Optional: define INCR_PACK_PARITY_EN to add parity_o, the XOR of all bits of word_o.
module incr_pack #(
  parameter  int NIBBLES = 4,
  localparam int LW      = $clog2(NIBBLES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [3:0]           nib_i,
  input  logic                 nib_valid_i,
  output logic                 nib_ready_o,
  input  logic                 flush_i,
  output logic [NIBBLES*4-1:0] word_o,
  output logic [LW-1:0]        word_len_o,
  output logic                 word_valid_o,
`ifdef INCR_PACK_PARITY_EN
  output logic                 parity_o,
`endif
  input  logic                 word_ready_i
);

  localparam int W = NIBBLES * 4;
  localparam logic [LW-1:0] LAST = LW'(NIBBLES - 1);

  logic [W-1:0]  asm_q;       // assembly register, filled from slot 0 upwards
  logic [LW-1:0] cnt;         // nibbles currently held in asm_q
  logic          flush_pend;  // flush requested, waiting for the output slot
  logic          live;        // low during reset so nothing is accepted

  logic          acc, xfer, slot_free;
  logic          flush_emit, full_emit, emit;
  logic [W-1:0]  ins_word, emit_word;
  logic [LW-1:0] emit_len;

  // Ready is a function of registered state only; word_ready_i never reaches it.
  assign nib_ready_o = live & ~(word_valid_o & ((cnt == LAST) | flush_pend));

  assign acc        = nib_valid_i & nib_ready_o;
  assign xfer       = word_valid_o & word_ready_i;
  assign slot_free  = ~word_valid_o | xfer;
  // A pending flush takes priority; a nibble accepted in that same cycle starts the next word.
  assign flush_emit = flush_pend & (cnt != '0) & slot_free;
  // Completion only happens with word_valid_o=0 because ready drops at cnt==LAST while busy.
  assign full_emit  = acc & (cnt == LAST) & ~flush_emit;
  assign emit       = flush_emit | full_emit;

  // Assembly with the incoming nibble written into slot cnt, and the word/length to emit.
  always_comb begin
    ins_word = asm_q;
    for (int k = 0; k < NIBBLES; k++) begin
      if (int'(cnt) == k) ins_word[k*4 +: 4] = nib_i;
    end
    emit_word = flush_emit ? asm_q : ins_word;
    emit_len  = flush_emit ? cnt : LW'(NIBBLES);
  end

  // Output holding register: load on emit, release on transfer, hold while stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_o       <= '0;
      word_len_o   <= '0;
      word_valid_o <= 1'b0;
`ifdef INCR_PACK_PARITY_EN
      parity_o     <= 1'b0;
`endif
    end else if (emit) begin
      word_o       <= emit_word;
      word_len_o   <= emit_len;
      word_valid_o <= 1'b1;
`ifdef INCR_PACK_PARITY_EN
      parity_o     <= ^emit_word;
`endif
    end else if (xfer) begin
      word_valid_o <= 1'b0;
    end
  end

  // Assembly register, fill count and sticky flush request.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      asm_q      <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      live       <= 1'b0;
    end else begin
      live <= 1'b1;
      if (flush_emit) begin
        asm_q      <= acc ? W'(nib_i) : '0;
        cnt        <= acc ? LW'(1) : '0;
        flush_pend <= acc & flush_i;
      end else if (full_emit) begin
        asm_q      <= '0;
        cnt        <= '0;
        flush_pend <= 1'b0;
      end else begin
        if (acc) begin
          asm_q <= ins_word;
          cnt   <= cnt + LW'(1);
        end
        // A flush on an empty assembly with no incoming nibble has nothing to emit.
        if (flush_i & (acc | (cnt != '0))) flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_incr_pack.sv
module tb_incr_pack;
  localparam int N  = 4;
  localparam int W  = N * 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    nib;
  logic          nib_valid, nib_ready, flush, word_valid, word_ready;
  logic [W-1:0]  word;
  logic [LW-1:0] word_len;
`ifdef INCR_PACK_PARITY_EN
  logic          parity;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  incr_pack #(.NIBBLES(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .nib_i(nib), .nib_valid_i(nib_valid),
    .nib_ready_o(nib_ready), .flush_i(flush), .word_o(word), .word_len_o(word_len),
    .word_valid_o(word_valid),
`ifdef INCR_PACK_PARITY_EN
    .parity_o(parity),
`endif
    .word_ready_i(word_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic nv, input logic [3:0] n, input logic fl, input logic wr);
    nib_valid = nv; nib = n; flush = fl; word_ready = wr;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       nv; logic [3:0] nib; logic fl; logic wr;
    logic       rdy; logic v; logic [W-1:0] word; logic [LW-1:0] len;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic nv, input logic [3:0] n, input logic fl, input logic wr,
                     input logic rdy, input logic v, input logic [W-1:0] w, input logic [LW-1:0] l);
    vec_t e;
    e.nv = nv; e.nib = n; e.fl = fl; e.wr = wr; e.rdy = rdy; e.v = v; e.word = w; e.len = l;
    tbl.push_back(e);
  endtask

  // ---------------- behavioural reference model ----------------
  int           mq[$];     // nibbles collected so far, oldest first
  bit           m_fp;      // flush waiting
  bit           m_ov;      // output word present
  logic [W-1:0] m_ow;
  int           m_olen;
  bit           m_par;

  function automatic bit m_ready();
    return !(m_ov && (mq.size() == N - 1 || m_fp));
  endfunction

  task automatic m_emit();
    m_ow = '0;
    foreach (mq[k]) m_ow = m_ow | (W'(mq[k] & 15) << (4 * k));
    m_olen = mq.size();
    m_ov   = 1'b1;
    m_par  = ^m_ow;
    mq.delete();
    m_fp   = 1'b0;
  endtask

  task automatic m_step(input bit nv, input int n, input bit fl, input bit wr);
    bit acc, xf, free;
    acc  = nv && m_ready();
    xf   = m_ov && wr;
    free = !m_ov || xf;
    if (m_fp && mq.size() > 0 && free) begin
      m_emit();
      if (acc) begin
        mq.push_back(n);
        m_fp = fl;
      end
    end else begin
      if (acc) mq.push_back(n);
      if (fl && mq.size() > 0) m_fp = 1'b1;
      if (mq.size() == N) m_emit();
      else if (xf) m_ov = 1'b0;
    end
  endtask

  initial begin
    drive(0, 4'h0, 0, 0);
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_ready", nib_ready, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_word",  word, 0);
    chk("rst_len",   word_len, 0);
    rst_n = 1'b1;
    cyc();
    chk("release_ready", nib_ready, 1);
    chk("release_valid", word_valid, 0);

    // fill 1,2,3,4; valid lasts exactly one cycle
    add(1, 4'h1, 0, 1, 1, 0, 16'h0, 0);
    add(1, 4'h2, 0, 1, 1, 0, 16'h0, 0);
    add(1, 4'h3, 0, 1, 1, 0, 16'h0, 0);
    add(1, 4'h4, 0, 1, 1, 1, 16'h4321, 4);
    add(0, 4'h0, 0, 1, 1, 0, 16'h0, 0);
    // backpressure: first word held, 5,6,7 accepted, 8 stalled
    add(1, 4'h1, 0, 0, 1, 0, 16'h0, 0);
    add(1, 4'h2, 0, 0, 1, 0, 16'h0, 0);
    add(1, 4'h3, 0, 0, 1, 0, 16'h0, 0);
    add(1, 4'h4, 0, 0, 1, 1, 16'h4321, 4);
    add(1, 4'h5, 0, 0, 1, 1, 16'h4321, 4);
    add(1, 4'h6, 0, 0, 1, 1, 16'h4321, 4);
    add(1, 4'h7, 0, 0, 0, 1, 16'h4321, 4);
    add(1, 4'h8, 0, 0, 0, 1, 16'h4321, 4);
    add(1, 4'h8, 0, 1, 1, 0, 16'h0, 0);
    add(1, 4'h8, 0, 1, 1, 1, 16'h8765, 4);
    add(0, 4'h0, 0, 1, 1, 0, 16'h0, 0);
    // partial flush, then flush with nothing collected
    add(1, 4'hA, 0, 1, 1, 0, 16'h0, 0);
    add(1, 4'hB, 0, 1, 1, 0, 16'h0, 0);
    add(0, 4'h0, 1, 1, 1, 0, 16'h0, 0);
    add(0, 4'h0, 0, 1, 1, 1, 16'h00BA, 2);
    add(0, 4'h0, 0, 1, 1, 0, 16'h0, 0);
    add(0, 4'h0, 1, 1, 1, 0, 16'h0, 0);
    add(0, 4'h0, 0, 1, 1, 0, 16'h0, 0);
    add(0, 4'h0, 0, 1, 1, 0, 16'h0, 0);
    // flush together with the completing nibble: one full word only
    add(1, 4'h1, 0, 1, 1, 0, 16'h0, 0);
    add(1, 4'h2, 0, 1, 1, 0, 16'h0, 0);
    add(1, 4'h3, 0, 1, 1, 0, 16'h0, 0);
    add(1, 4'hF, 1, 1, 1, 1, 16'hF321, 4);
    add(0, 4'h0, 0, 1, 1, 0, 16'h0, 0);
    add(0, 4'h0, 0, 1, 1, 0, 16'h0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].nv, tbl[i].nib, tbl[i].fl, tbl[i].wr);
      cyc();
      chk($sformatf("vec%0d_ready", i), nib_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), word_valid, tbl[i].v);
      if (tbl[i].v) begin
        chk($sformatf("vec%0d_word", i), word, tbl[i].word);
        chk($sformatf("vec%0d_len", i), word_len, tbl[i].len);
      end
    end

    // reset mid-operation with a word pending and two nibbles collected
    for (int k = 1; k <= 6; k++) begin
      drive(1, 4'(k), 0, 0);
      cyc();
    end
    chk("pre_rst_valid", word_valid, 1);
    drive(0, 4'h0, 0, 0);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_ready", nib_ready, 0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ready", nib_ready, 1);
    for (int k = 0; k < 4; k++) begin
      drive(1, 4'h1, 0, 1);
      cyc();
    end
    chk("post_rst_valid", word_valid, 1);
    chk("post_rst_word", word, 16'h1111);
    chk("post_rst_len", word_len, 4);
    drive(0, 4'h0, 0, 1);
    cyc();

`ifdef INCR_PACK_PARITY_EN
    drive(1, 4'h7, 1, 1); cyc();
    drive(0, 4'h0, 0, 1); cyc();
    chk("par7_word", word, 16'h0007);
    chk("par7_parity", parity, 1);
    cyc();
    drive(1, 4'h3, 1, 1); cyc();
    drive(0, 4'h0, 0, 1); cyc();
    chk("par3_word", word, 16'h0003);
    chk("par3_parity", parity, 0);
    cyc();
`endif

    // randomized run against the reference model
    drive(0, 4'h0, 0, 0);
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    mq.delete(); m_fp = 0; m_ov = 0; m_ow = '0; m_olen = 0; m_par = 0;
    for (int c = 0; c < 3000; c++) begin
      bit nv, fl, wr;
      logic [3:0] n;
      chk("rand_ready", nib_ready, m_ready());
      chk("rand_valid", word_valid, m_ov);
      if (m_ov) begin
        chk("rand_word", word, m_ow);
        chk("rand_len", word_len, m_olen);
`ifdef INCR_PACK_PARITY_EN
        chk("rand_parity", parity, m_par);
`endif
      end
      nv = ($urandom_range(0, 9) < 7);
      n  = 4'($urandom);
      fl = ($urandom_range(0, 9) == 0);
      wr = ($urandom_range(0, 9) < 6);
      drive(nv, n, fl, wr);
      m_step(nv, int'(n), fl, wr);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
